// File: rtl/halfword_compressor.sv
// Sends 32-bit words on a 16-bit halfword stream: sign-extended words go as one
// halfword, all others as high then low. Optional counters: HALFWORD_COMPRESSOR_STATS_EN.
module halfword_compressor #(
  parameter int COMPRESS = 1,
  parameter int CNT_W    = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [0:31]     in_word,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [0:15]     out_half,
  output logic [0:1]      out_tag,
  output logic            out_last
`ifdef HALFWORD_COMPRESSOR_STATS_EN
  ,
  output logic [0:CNT_W-1] cnt_words,
  output logic [0:CNT_W-1] cnt_comp
`endif
);

  typedef enum logic [1:0] {IDLE, ONE, HI, LO} state_t;

  localparam bit COMP_EN = (COMPRESS != 0);

  state_t      state_q, state_d;
  logic [0:15] half_q, half_d;
  logic [0:1]  tag_q, tag_d;
  logic        last_q, last_d;
  logic [0:15] low_q, low_d;
  logic        accept;
  logic        compressible;

  // The upper 17 bits must agree for the low half alone to reconstruct the word.
  assign compressible = COMP_EN && ((&in_word[0:16]) || !(|in_word[0:16]));

  assign out_valid = (state_q != IDLE);
  assign in_ready  = (state_q == IDLE) || (out_valid && out_ready && last_q);
  assign accept    = in_valid && in_ready;
  assign out_half  = half_q;
  assign out_tag   = tag_q;
  assign out_last  = last_q;

  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    tag_d   = tag_q;
    last_d  = last_q;
    low_d   = low_q;
    if (accept) begin
      if (compressible) begin
        state_d = ONE;
        half_d  = in_word[16:31];
        tag_d   = 2'b00;
        last_d  = 1'b1;
      end else begin
        state_d = HI;
        half_d  = in_word[0:15];
        tag_d   = 2'b01;
        last_d  = 1'b0;
        low_d   = in_word[16:31];
      end
    end else if (out_ready) begin
      case (state_q)
        HI: begin
          state_d = LO;
          half_d  = low_q;
          tag_d   = 2'b10;
          last_d  = 1'b1;
        end
        ONE, LO: state_d = IDLE;
        default: ;
      endcase
    end
  end

  // Output register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      half_q  <= '0;
      tag_q   <= 2'b00;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      tag_q   <= tag_d;
      last_q  <= last_d;
    end
  end

  // Held low half is only read after HI, so it needs no reset.
  always_ff @(posedge clk) begin
    low_q <= low_d;
  end

`ifdef HALFWORD_COMPRESSOR_STATS_EN
  logic [0:CNT_W-1] cnt_words_q, cnt_words_d;
  logic [0:CNT_W-1] cnt_comp_q, cnt_comp_d;

  function automatic logic [0:CNT_W-1] sat_inc(input logic [0:CNT_W-1] v);
    if (&v) return v;
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  always_comb begin
    cnt_words_d = cnt_words_q;
    cnt_comp_d  = cnt_comp_q;
    if (accept) begin
      cnt_words_d = sat_inc(cnt_words_q);
      if (compressible) cnt_comp_d = sat_inc(cnt_comp_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_words_q <= '0;
      cnt_comp_q  <= '0;
    end else begin
      cnt_words_q <= cnt_words_d;
      cnt_comp_q  <= cnt_comp_d;
    end
  end

  assign cnt_words = cnt_words_q;
  assign cnt_comp  = cnt_comp_q;
`endif

endmodule
